// File: rtl/pulse_train_gen_pkg.sv
// Shared state type, default width and length-saturation helper for the pulse train generator.
package pulse_gen_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int SAT_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pg_state_t;

  // A programmed length of 0 behaves as a length of 1.
  function automatic logic [SAT_W-1:0] sat1(input logic [SAT_W-1:0] x);
    logic [SAT_W-1:0] r;
    if (x == {SAT_W{1'b0}}) begin
      r = {{(SAT_W-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control, configuration and waveform/status bundle between a requester and the pulse train generator.
interface pulse_train_gen_if
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] num_pulses;
  logic             signal;
  logic             rise_strobe;
  logic             fall_strobe;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, abort, high_len, low_len, num_pulses,
    input  signal, rise_strobe, fall_strobe, busy, done, aborted
  );

  modport slave (
    input  start, abort, high_len, low_len, num_pulses,
    output signal, rise_strobe, fall_strobe, busy, done, aborted
  );

endinterface

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter that holds at zero; times the current high or low phase.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train: N pulses of max(H,1) high cycles separated by max(L,1) low cycles,
// with registered edge strobes and done/aborted completion pulses.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pulse_train_gen_if.slave bus
);

  pg_state_t        state_q, state_d;
  logic [CNT_W-1:0] prem_q, prem_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             signal_q, signal_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_zero_s;

  // The timer holds (length - 1) so that a phase lasts exactly max(length,1) cycles.
  function automatic logic [CNT_W-1:0] phase_init(input logic [CNT_W-1:0] len);
    return CNT_W'(sat1(SAT_W'(len)) - SAT_W'(1));
  endfunction

  phase_timer #(.W(CNT_W)) u_pcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state, counter and output decode; abort outranks start and phase events.
  always_comb begin
    state_d    = state_q;
    prem_d     = prem_q;
    high_d     = high_q;
    low_d      = low_q;
    signal_d   = signal_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = {CNT_W{1'b0}};

    case (state_q)
      IDLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.start) begin
          if (bus.num_pulses == {CNT_W{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            state_d    = HIGH;
            signal_d   = 1'b1;
            rise_d     = 1'b1;
            high_d     = bus.high_len;
            low_d      = bus.low_len;
            prem_d     = bus.num_pulses - CNT_W'(1);
            tmr_load_s = 1'b1;
            tmr_val_s  = phase_init(bus.high_len);
          end
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (bus.abort) begin
          state_d    = IDLE;
          signal_d   = 1'b0;
          fall_d     = signal_q;
          aborted_d  = 1'b1;
          prem_d     = {CNT_W{1'b0}};
          tmr_load_s = 1'b1;
        end else if (!tmr_zero_s) begin
          state_d = HIGH;
        end else if (prem_q != {CNT_W{1'b0}}) begin
          state_d    = LOW;
          signal_d   = 1'b0;
          fall_d     = 1'b1;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_init(low_q);
        end else begin
          // Last pulse ends the train directly; there is no trailing low phase.
          state_d  = IDLE;
          signal_d = 1'b0;
          fall_d   = 1'b1;
          done_d   = 1'b1;
        end
      end
      LOW: begin
        if (bus.abort) begin
          state_d    = IDLE;
          signal_d   = 1'b0;
          fall_d     = signal_q;
          aborted_d  = 1'b1;
          prem_d     = {CNT_W{1'b0}};
          tmr_load_s = 1'b1;
        end else if (tmr_zero_s) begin
          state_d    = HIGH;
          signal_d   = 1'b1;
          rise_d     = 1'b1;
          prem_d     = prem_q - CNT_W'(1);
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_init(high_q);
        end else begin
          state_d = LOW;
        end
      end
      default: begin
        state_d    = IDLE;
        signal_d   = 1'b0;
        prem_d     = {CNT_W{1'b0}};
        tmr_load_s = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prem_q    <= {CNT_W{1'b0}};
      high_q    <= {CNT_W{1'b0}};
      low_q     <= {CNT_W{1'b0}};
      signal_q  <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prem_q    <= prem_d;
      high_q    <= high_d;
      low_q     <= low_d;
      signal_q  <= signal_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.signal      = signal_q;
  assign bus.rise_strobe = rise_q;
  assign bus.fall_strobe = fall_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed and loopback bench for pulse_train_gen; expected waveforms are hand-computed bit traces
// where bit i holds the value in cycle i+1 after the start request.
module tb_pulse_train_gen;
  import pulse_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_train_gen_if #(.CNT_W(CNT_W_DEF)) bus ();

  pulse_train_gen #(.CNT_W(CNT_W_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] sig_tr, rise_tr, fall_tr, busy_tr, done_tr, abrt_tr;

  // Reference edge detectors fed from the generated waveform, plus one-cycle delayed strobes.
  logic sig_prev_q, rdet_q, fdet_q, bdet_q, rise_d1_q, fall_d1_q, both_d1_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_prev_q <= 1'b0;
      rdet_q     <= 1'b0;
      fdet_q     <= 1'b0;
      bdet_q     <= 1'b0;
      rise_d1_q  <= 1'b0;
      fall_d1_q  <= 1'b0;
      both_d1_q  <= 1'b0;
    end else begin
      sig_prev_q <= bus.signal;
      rdet_q     <= bus.signal & ~sig_prev_q;
      fdet_q     <= ~bus.signal & sig_prev_q;
      bdet_q     <= bus.signal ^ sig_prev_q;
      rise_d1_q  <= bus.rise_strobe;
      fall_d1_q  <= bus.fall_strobe;
      both_d1_q  <= bus.rise_strobe | bus.fall_strobe;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // {signal, rise, fall, busy, done, aborted}
  function automatic logic [31:0] outs();
    return {26'd0, bus.signal, bus.rise_strobe, bus.fall_strobe, bus.busy, bus.done, bus.aborted};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int h, input int l, input int n);
    bus.high_len   = 8'(h);
    bus.low_len    = 8'(l);
    bus.num_pulses = 8'(n);
  endtask

  // Steps n cycles recording outputs; optionally re-pulses start with new settings after cycle poke_cyc.
  task automatic record(input int n, input int poke_cyc);
    sig_tr  = 32'd0;
    rise_tr = 32'd0;
    fall_tr = 32'd0;
    busy_tr = 32'd0;
    done_tr = 32'd0;
    abrt_tr = 32'd0;
    for (int i = 0; i < n; i++) begin
      step();
      sig_tr[i]  = bus.signal;
      rise_tr[i] = bus.rise_strobe;
      fall_tr[i] = bus.fall_strobe;
      busy_tr[i] = bus.busy;
      done_tr[i] = bus.done;
      abrt_tr[i] = bus.aborted;
      bus.start  = (i + 1 == poke_cyc) ? 1'b1 : 1'b0;
      if (i + 1 == poke_cyc) begin
        bus.high_len   = 8'd7;
        bus.num_pulses = 8'd5;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int h, l, n, hp, lp, exp_busy, busy_n, rise_n, bad;
    logic got_done;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_outs", outs(), 32'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk_eq("idle_outs", outs(), 32'h00);
    end

    // H=3 L=2 N=2
    cfg(3, 2, 2);
    bus.start = 1'b1;
    record(12, -1);
    chk_eq("basic_sig",  sig_tr,  32'h0E7);
    chk_eq("basic_rise", rise_tr, 32'h021);
    chk_eq("basic_fall", fall_tr, 32'h108);
    chk_eq("basic_done", done_tr, 32'h100);
    chk_eq("basic_busy", busy_tr, 32'h0FF);
    chk_eq("basic_abrt", abrt_tr, 32'h000);

    // Same train with a start re-pulse and new settings during HIGH: nothing changes.
    cfg(3, 2, 2);
    bus.start = 1'b1;
    record(12, 2);
    chk_eq("repulse_sig",  sig_tr,  32'h0E7);
    chk_eq("repulse_busy", busy_tr, 32'h0FF);
    chk_eq("repulse_done", done_tr, 32'h100);

    // H=0 L=0 N=3
    cfg(0, 0, 3);
    bus.start = 1'b1;
    record(8, -1);
    chk_eq("zero_sig",  sig_tr,  32'h15);
    chk_eq("zero_rise", rise_tr, 32'h15);
    chk_eq("zero_fall", fall_tr, 32'h2A);
    chk_eq("zero_done", done_tr, 32'h20);
    chk_eq("zero_busy", busy_tr, 32'h1F);

    // N=0: empty train
    cfg(4, 4, 0);
    bus.start = 1'b1;
    record(4, -1);
    chk_eq("empty_done", done_tr, 32'h1);
    chk_eq("empty_sig",  sig_tr,  32'h0);
    chk_eq("empty_busy", busy_tr, 32'h0);

    // Abort in HIGH at cycle 2, restart at cycle 3
    cfg(5, 0, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_eq("abort_high_outs", outs(), 32'h09);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_eq("restart_outs", outs(), 32'h34);
    record(8, -1);
    chk_eq("restart_sig",  sig_tr,  32'h0F);
    chk_eq("restart_fall", fall_tr, 32'h10);
    chk_eq("restart_done", done_tr, 32'h10);

    // Abort in LOW: no falling strobe since signal is already low
    cfg(1, 4, 2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_eq("abort_low_outs", outs(), 32'h01);

    // Abort together with start in IDLE: both ignored
    cfg(2, 2, 2);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk_eq("idle_abort_start", outs(), 32'h00);
    step();
    chk_eq("idle_abort_after", outs(), 32'h00);

    // Asynchronous reset in the middle of a LOW phase
    cfg(1, 5, 2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk_eq("pre_rst_low", outs(), 32'h04);
    #3;
    rst = 1'b1;
    #1;
    chk_eq("rst_async", outs(), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_eq("post_rst_idle", outs(), 32'h00);

    // Random trains: length, pulse count and edge-detector loopback
    for (int t = 0; t < 200; t++) begin
      h = int'($urandom_range(0, 4));
      l = int'($urandom_range(0, 4));
      n = int'($urandom_range(0, 4));
      hp = (h == 0) ? 1 : h;
      lp = (l == 0) ? 1 : l;
      exp_busy = (n == 0) ? 0 : n * hp + (n - 1) * lp;
      cfg(h, l, n);
      bus.start = 1'b1;
      busy_n = 0;
      rise_n = 0;
      bad = 0;
      got_done = 1'b0;
      for (int c = 0; c < 100 && !got_done; c++) begin
        step();
        bus.start = 1'b0;
        if (bus.busy) busy_n++;
        if (bus.rise_strobe) rise_n++;
        if (rdet_q !== rise_d1_q || fdet_q !== fall_d1_q || bdet_q !== both_d1_q) bad++;
        if (bus.done) got_done = 1'b1;
      end
      bus.start = 1'b0;
      chk_eq("rnd_done",     32'(got_done), 32'd1);
      chk_eq("rnd_busy_len", 32'(busy_n),   32'(exp_busy));
      chk_eq("rnd_pulses",   32'(rise_n),   32'(n));
      chk_eq("rnd_loopback", 32'(bad),      32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
